// File: rtl/regwrite_sched.sv
// regwrite_sched: round-robin arbiter that serialises one requester's masked
// W-bit word onto the one-hot ctrl/in bit-write port of regwrite_1.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and drives bit 0 on grant
// SHIFT | driving bits 1..W-1, then pulses done and returns to IDLE
module regwrite_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] wdata_i,
    input  logic [NREQ*W-1:0] wmask_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic [W-1:0]      ctrl_o,
    output logic              in_o,
    output logic              busy_o
);

    localparam int LW = $clog2(NREQ);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   last_q,  last_d;
    logic [LW-1:0]   win_q,   win_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [W-1:0]    data_q,  data_d;
    logic [W-1:0]    mask_q,  mask_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [NREQ-1:0] done_q,  done_d;
    logic [W-1:0]    ctrl_q,  ctrl_d;
    logic            in_q,    in_d;
    logic            busy_q,  busy_d;

    logic [LW-1:0]   cand;
    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic [W-1:0]    cand_data;
    logic [W-1:0]    cand_mask;
    logic [IW-1:0]   idx_nxt;

    // Scan from last+1 upward, wrapping, so the previous winner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = LW'((int'(last_q) + off) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign cand_data = wdata_i[int'(win_idx)*W +: W];
    assign cand_mask = wmask_i[int'(win_idx)*W +: W];
    assign idx_nxt   = idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        ctrl_d  = '0;
        in_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    data_d  = cand_data;
                    mask_d  = cand_mask;
                    win_d   = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    idx_d   = '0;
                    ctrl_d  = cand_mask[0] ? W'(1) : '0;
                    in_d    = cand_mask[0] & cand_data[0];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q != IDX_LAST) begin
                    idx_d  = idx_nxt;
                    ctrl_d = mask_q[idx_nxt] ? (W'(1) << idx_nxt) : '0;
                    in_d   = mask_q[idx_nxt] & data_q[idx_nxt];
                end else begin
                    gnt_d   = '0;
                    done_d  = NREQ'(1) << win_q;
                    last_d  = win_q;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
    end

    // Async clear drops ctrl immediately so a reset never leaves a write pending.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            win_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            ctrl_q  <= '0;
            in_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ctrl_q  <= ctrl_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign ctrl_o = ctrl_q;
    assign in_o   = in_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_regwrite_sched.sv
// Testbench for regwrite_sched: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model and a regwrite_1 model.
module tb_regwrite_sched;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*W-1:0] wdata_i;
    logic [NREQ*W-1:0] wmask_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   done_o;
    logic [W-1:0]      ctrl_o;
    logic              in_o;
    logic              busy_o;

    logic [W-1:0]      rout = '0;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                m_last;

    regwrite_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   (req_i),
        .wdata_i (wdata_i),
        .wmask_i (wmask_i),
        .gnt_o   (gnt_o),
        .done_o  (done_o),
        .ctrl_o  (ctrl_o),
        .in_o    (in_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // regwrite_1 stand-in: writes the selected bit; untouched by reset
    always @(posedge clk_i) begin
        for (int i = 0; i < W; i++)
            if (ctrl_o[i]) rout[i] <= in_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        for (int o = 1; o <= NREQ; o++)
            if (r[(last + o) % NREQ]) return (last + o) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int r);
        logic [NREQ-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] exp_ctrl(input logic [W-1:0] m, input int k);
        logic [W-1:0] v;
        v = '0;
        if (m[k]) v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] exp_rout(input logic [W-1:0] old, input logic [W-1:0] d,
                                              input logic [W-1:0] m);
        return (old & ~m) | (d & m);
    endfunction

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        req_i   = '0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        m_last  = NREQ - 1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        req_i   = '0;
        wdata_i = '0;
        wmask_i = '0;
        repeat (2) @(negedge clk_i);
        n_checks++; if (gnt_o !== '0) $display("FAIL reset_gnt got %b exp 0", gnt_o); else n_pass++;
        n_checks++; if (done_o !== '0) $display("FAIL reset_done got %b exp 0", done_o); else n_pass++;
        n_checks++; if (ctrl_o !== '0) $display("FAIL reset_ctrl got %b exp 0", ctrl_o); else n_pass++;
        n_checks++; if (in_o !== 1'b0) $display("FAIL reset_in got %b exp 0", in_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_o); else n_pass++;
        rst_n_i = 1'b1;
        m_last  = NREQ - 1;
        step();
        n_checks++; if (busy_o !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy_o); else n_pass++;
    endtask

    task automatic test_single_write();
        logic [3:0][W-1:0] lit_ctrl;
        logic [W-1:0]      lit_in;
        lit_ctrl = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        lit_in   = 4'b1011;
        req_i         = 4'b0001;
        wdata_i[3:0]  = 4'b1011;
        wmask_i[3:0]  = 4'b1111;
        for (int k = 0; k < W; k++) begin
            step();
            n_checks++; if (gnt_o !== 4'b0001) $display("FAIL single_gnt k=%0d got %b exp 0001", k, gnt_o); else n_pass++;
            n_checks++; if (ctrl_o !== lit_ctrl[k]) $display("FAIL single_ctrl k=%0d got %b exp %b", k, ctrl_o, lit_ctrl[k]); else n_pass++;
            n_checks++; if (in_o !== lit_in[k]) $display("FAIL single_in k=%0d got %b exp %b", k, in_o, lit_in[k]); else n_pass++;
            n_checks++; if (busy_o !== 1'b1) $display("FAIL single_busy k=%0d got %b exp 1", k, busy_o); else n_pass++;
            n_checks++; if (done_o !== '0) $display("FAIL single_early_done k=%0d got %b exp 0", k, done_o); else n_pass++;
        end
        step();
        n_checks++; if (done_o !== 4'b0001) $display("FAIL single_done got %b exp 0001", done_o); else n_pass++;
        n_checks++; if (gnt_o !== '0) $display("FAIL single_gnt_off got %b exp 0", gnt_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL single_busy_off got %b exp 0", busy_o); else n_pass++;
        n_checks++; if (rout !== 4'b1011) $display("FAIL single_rout got %b exp 1011", rout); else n_pass++;
        req_i  = '0;
        m_last = 0;
        step();
        n_checks++; if (done_o !== '0) $display("FAIL single_done_once got %b exp 0", done_o); else n_pass++;
    endtask

    task automatic test_partial_mask();
        logic [3:0][W-1:0] lit_ctrl;
        logic [W-1:0]      lit_in;
        int                w;
        lit_ctrl = {4'b0000, 4'b0100, 4'b0010, 4'b0000};
        lit_in   = 4'b0100;
        req_i          = 4'b0100;
        wdata_i[11:8]  = 4'b0100;
        wmask_i[11:8]  = 4'b0110;
        w = pick(req_i, m_last);
        for (int k = 0; k < W; k++) begin
            step();
            n_checks++; if (gnt_o !== onehot(w)) $display("FAIL partial_gnt k=%0d got %b exp %b", k, gnt_o, onehot(w)); else n_pass++;
            n_checks++; if (ctrl_o !== lit_ctrl[k]) $display("FAIL partial_ctrl k=%0d got %b exp %b", k, ctrl_o, lit_ctrl[k]); else n_pass++;
            n_checks++; if (in_o !== lit_in[k]) $display("FAIL partial_in k=%0d got %b exp %b", k, in_o, lit_in[k]); else n_pass++;
        end
        step();
        n_checks++; if (done_o !== 4'b0100) $display("FAIL partial_done got %b exp 0100", done_o); else n_pass++;
        n_checks++; if (rout !== 4'b1101) $display("FAIL partial_rout got %b exp 1101", rout); else n_pass++;
        req_i  = '0;
        m_last = w;
        step();
    endtask

    task automatic test_round_robin();
        int           w;
        logic [W-1:0] d, m, old;
        do_reset();
        wdata_i = (NREQ*W)'($urandom);
        wmask_i = (NREQ*W)'($urandom);
        req_i   = '1;
        for (int t = 0; t < 5; t++) begin
            w   = pick(req_i, m_last);
            d   = wdata_i[w*W +: W];
            m   = wmask_i[w*W +: W];
            old = rout;
            for (int k = 0; k < W; k++) begin
                step();
                n_checks++; if (gnt_o !== onehot(w)) $display("FAIL rr_gnt t=%0d k=%0d got %b exp %b", t, k, gnt_o, onehot(w)); else n_pass++;
                n_checks++; if (ctrl_o !== exp_ctrl(m, k)) $display("FAIL rr_ctrl t=%0d k=%0d got %b exp %b", t, k, ctrl_o, exp_ctrl(m, k)); else n_pass++;
                n_checks++; if (in_o !== (d[k] & m[k])) $display("FAIL rr_in t=%0d k=%0d got %b exp %b", t, k, in_o, d[k] & m[k]); else n_pass++;
            end
            step();
            n_checks++; if (done_o !== onehot(w)) $display("FAIL rr_done t=%0d got %b exp %b", t, done_o, onehot(w)); else n_pass++;
            n_checks++; if (gnt_o !== '0) $display("FAIL rr_gnt_gap t=%0d got %b exp 0", t, gnt_o); else n_pass++;
            n_checks++; if (rout !== exp_rout(old, d, m)) $display("FAIL rr_rout t=%0d got %b exp %b", t, rout, exp_rout(old, d, m)); else n_pass++;
            m_last = w;
        end
        req_i = '0;
        step();
    endtask

    task automatic test_drop_change();
        int           w;
        logic [W-1:0] d, m, old;
        d   = 4'b0110;
        m   = 4'b1111;
        old = rout;
        req_i         = 4'b0010;
        wdata_i[7:4]  = d;
        wmask_i[7:4]  = m;
        w = pick(req_i, m_last);
        for (int k = 0; k < W; k++) begin
            step();
            n_checks++; if (ctrl_o !== exp_ctrl(m, k)) $display("FAIL drop_ctrl k=%0d got %b exp %b", k, ctrl_o, exp_ctrl(m, k)); else n_pass++;
            n_checks++; if (in_o !== (d[k] & m[k])) $display("FAIL drop_in k=%0d got %b exp %b", k, in_o, d[k] & m[k]); else n_pass++;
            if (k == 1) begin
                req_i        = '0;
                wdata_i[7:4] = ~d;
                wmask_i[7:4] = 4'b0001;
            end
        end
        step();
        n_checks++; if (done_o !== onehot(w)) $display("FAIL drop_done got %b exp %b", done_o, onehot(w)); else n_pass++;
        n_checks++; if (rout !== exp_rout(old, d, m)) $display("FAIL drop_rout got %b exp %b", rout, exp_rout(old, d, m)); else n_pass++;
        m_last = w;
        step();
        n_checks++; if (gnt_o !== '0) $display("FAIL drop_no_regrant got %b exp 0", gnt_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [W-1:0] d, old, exp_r;
        old = rout;
        d   = ~old;
        req_i         = 4'b0001;
        wdata_i[3:0]  = d;
        wmask_i[3:0]  = 4'b1111;
        repeat (3) step();
        n_checks++; if (ctrl_o !== 4'b0100) $display("FAIL arst_bit2 got %b exp 0100", ctrl_o); else n_pass++;
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++; if (ctrl_o !== '0) $display("FAIL arst_ctrl got %b exp 0", ctrl_o); else n_pass++;
        n_checks++; if (gnt_o !== '0) $display("FAIL arst_gnt got %b exp 0", gnt_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL arst_busy got %b exp 0", busy_o); else n_pass++;
        req_i = '0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        m_last  = NREQ - 1;
        exp_r   = {old[3:2], d[1:0]};
        n_checks++; if (rout !== exp_r) $display("FAIL arst_rout got %b exp %b", rout, exp_r); else n_pass++;
        step();
        n_checks++; if (done_o !== '0) $display("FAIL arst_no_done got %b exp 0", done_o); else n_pass++;
        req_i = '1;
        step();
        n_checks++; if (gnt_o !== onehot(pick(4'b1111, m_last))) $display("FAIL arst_first_win got %b exp %b", gnt_o, onehot(pick(4'b1111, m_last))); else n_pass++;
        repeat (W) step();
        n_checks++; if (done_o !== 4'b0001) $display("FAIL arst_done_after got %b exp 0001", done_o); else n_pass++;
        req_i  = '0;
        m_last = 0;
        step();
    endtask

    task automatic test_zero_mask();
        int           w;
        logic [W-1:0] old;
        old = rout;
        req_i           = 4'b1000;
        wdata_i[15:12]  = 4'b1111;
        wmask_i[15:12]  = 4'b0000;
        w = pick(req_i, m_last);
        for (int k = 0; k < W; k++) begin
            step();
            n_checks++; if (ctrl_o !== '0) $display("FAIL zero_ctrl k=%0d got %b exp 0", k, ctrl_o); else n_pass++;
            n_checks++; if (busy_o !== 1'b1) $display("FAIL zero_busy k=%0d got %b exp 1", k, busy_o); else n_pass++;
        end
        step();
        n_checks++; if (done_o !== onehot(w)) $display("FAIL zero_done got %b exp %b", done_o, onehot(w)); else n_pass++;
        n_checks++; if (rout !== old) $display("FAIL zero_rout got %b exp %b", rout, old); else n_pass++;
        req_i  = '0;
        m_last = w;
        step();
    endtask

    task automatic test_random();
        int           w;
        logic [W-1:0] d, m, old;
        for (int it = 0; it < 60; it++) begin
            req_i   = ($urandom_range(0, 4) == 0) ? '0 : NREQ'($urandom);
            wdata_i = (NREQ*W)'($urandom);
            wmask_i = (NREQ*W)'($urandom);
            w   = pick(req_i, m_last);
            old = rout;
            if (w >= 0) begin
                d = wdata_i[w*W +: W];
                m = wmask_i[w*W +: W];
            end
            step();
            if (w < 0) begin
                n_checks++; if (gnt_o !== '0 || busy_o !== 1'b0 || ctrl_o !== '0) $display("FAIL rand_idle it=%0d gnt %b busy %b ctrl %b exp all 0", it, gnt_o, busy_o, ctrl_o); else n_pass++;
                continue;
            end
            for (int k = 0; k < W; k++) begin
                if (k > 0) begin
                    req_i   = NREQ'($urandom);
                    wdata_i = (NREQ*W)'($urandom);
                    wmask_i = (NREQ*W)'($urandom);
                    step();
                end
                n_checks++; if (gnt_o !== onehot(w)) $display("FAIL rand_gnt it=%0d k=%0d got %b exp %b", it, k, gnt_o, onehot(w)); else n_pass++;
                n_checks++; if (ctrl_o !== exp_ctrl(m, k)) $display("FAIL rand_ctrl it=%0d k=%0d got %b exp %b", it, k, ctrl_o, exp_ctrl(m, k)); else n_pass++;
                n_checks++; if (in_o !== (d[k] & m[k])) $display("FAIL rand_in it=%0d k=%0d got %b exp %b", it, k, in_o, d[k] & m[k]); else n_pass++;
                n_checks++; if (done_o !== '0 || busy_o !== 1'b1) $display("FAIL rand_busy it=%0d k=%0d done %b busy %b exp 0/1", it, k, done_o, busy_o); else n_pass++;
            end
            step();
            n_checks++; if (done_o !== onehot(w)) $display("FAIL rand_done it=%0d got %b exp %b", it, done_o, onehot(w)); else n_pass++;
            n_checks++; if (gnt_o !== '0 || ctrl_o !== '0 || busy_o !== 1'b0) $display("FAIL rand_end it=%0d gnt %b ctrl %b busy %b exp 0", it, gnt_o, ctrl_o, busy_o); else n_pass++;
            n_checks++; if (rout !== exp_rout(old, d, m)) $display("FAIL rand_rout it=%0d got %b exp %b", it, rout, exp_rout(old, d, m)); else n_pass++;
            m_last = w;
        end
        req_i = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_partial_mask();
        test_round_robin();
        test_drop_change();
        test_async_reset();
        test_zero_mask();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regwrite_sched.md
# regwrite_sched

Round-robin write scheduler for the bit-addressed `regwrite_1` register. It shares the register between `NREQ` requesters, each presenting a `W`-bit word and per-bit write mask. The winning word is serialised onto the register's one-hot `ctrl` / single-bit `in` write port, one bit per clock, and completion is reported back to the requester. It sits directly in front of `regwrite_1`; `ctrl` and `in` connect port-to-port.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `W`, 4, register width; must equal the `ctrl`/`rout` width of `regwrite_1`.

- `clk`  in  1  rising-edge clock, shared with `regwrite_1`.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  NREQ  per-requester write request; level, held until `done`.
- `wdata`  in  NREQ*W  requester r's word at `[r*W +: W]`.
- `wmask`  in  NREQ*W  requester r's bit-enable at `[r*W +: W]`; 1 = write that bit.
- `gnt`  out  NREQ  one-hot grant; high for the whole service of the winner.
- `done`  out  NREQ  one-cycle completion pulse to the served requester.
- `ctrl`  out  W  one-hot bit select to `regwrite_1`; all-zero = no write.
- `in`  out  1  bit value to `regwrite_1`.
- `busy`  out  1  high while a transaction is in progress (SHIFT state).

## Operation
- State machine states are IDLE and SHIFT. Pointer `last` holds the most recent winner. Bit counter `idx` is `clog2(W)` bits wide. All outputs are registered.
- **IDLE**
  - If `req` is nonzero, pick the first set requester scanning from `last+1` and wrapping modulo `NREQ`.
  - Latch that requester's `wdata`/`wmask` into internal registers.
  - Set `gnt` to the winner's one-hot, set `idx=0`, and go to SHIFT.
  - In the same edge, drive bit 0: `ctrl = wmask[0] ? 1<<0 : 0` and `in = wmask[0] & wdata[0]`.
- **SHIFT**, each edge:
  - If `idx < W-1`: increment `idx` and drive bit `idx+1` by the same rule.
  - If `idx == W-1`:
    - drive `ctrl=0`, `in=0`, `gnt=0`;
    - pulse `done[winner]=1`;
    - set `last=winner` and return to IDLE.
- Masked-off bits still consume a cycle with `ctrl=0`, so the bit position stays equal to the cycle offset. `ctrl` is always one-hot or zero and never multi-hot.
- Latched data is used throughout. Changes on `wdata`/`wmask` during service are ignored.
- If `req` of the winner drops mid-service, the transaction still completes and `done` still pulses.
- A requester that keeps `req` high after `done` is re-arbitrated. Round-robin ordering places it last behind any other pending requester, so no requester starves.
- All-zero mask: full W-cycle transaction with no writes; `done` pulses normally.
- `done` is zero in every cycle except the completion cycle. `done` and `gnt` are never high in the same cycle.

## Timing
- **Reset** (`rst_n` low, asynchronous): `gnt=0`, `done=0`, `ctrl=0`, `in=0`, `busy=0`, state IDLE, `idx=0`, `last=NREQ-1` (so requester 0 wins first).
  - Reset mid-transaction aborts immediately: `ctrl` goes to 0 without waiting for a clock, and no `done` is generated. Bits already written stay in `regwrite_1`.
- **Latency**: `req` sampled high in IDLE at edge E0 → `gnt` and bit 0 on `ctrl`/`in` after E0.
  - Bit k is driven after edge E0+k.
  - `regwrite_1` captures bit k at edge E0+k+1.
  - `done` is high for the cycle after E0+W.
- **Throughput**: W+1 cycles per transaction. The earliest next grant is at edge E0+W+1, giving back-to-back service with one non-writing cycle between words.
- **Boundary conditions**:
  - Simultaneous requests resolve by the round-robin pointer only.
  - A request arriving during SHIFT waits.
  - A request arriving in the `done` cycle is eligible at the next edge.

## Test plan
- **Single write**: after reset, `req=4'b0001`, `wdata[3:0]=4'b1011`, `wmask[3:0]=4'b1111`.
  - `ctrl` sequence 0001, 0010, 0100, 1000 with `in` 1, 1, 0, 1.
  - `done[0]` pulses at cycle 5; `rout` = 1011.
- **Partial mask**: register holds 1011; requester 2 writes `wdata=4'b0100`, `wmask=4'b0110`.
  - `ctrl` sequence 0000, 0010, 0100, 0000.
  - `rout` = 1101.
- **Round-robin fairness**: `req=4'b1111` held continuously.
  - Grants in order 0, 1, 2, 3, 0, each 5 cycles apart.
  - `done` pulses in the same order.
- **Request drop / data change mid-service**: requester 1 deasserts `req` and changes `wdata` after bit 1.
  - Remaining bits use the latched word; `done[1]` still pulses.
- **Async reset mid-transaction**: assert `rst_n=0` between clock edges during bit 2.
  - `ctrl`, `gnt`, and `busy` go to 0 before the next edge; no `done`.
  - After release, requester 0 wins first.
- **All-zero mask**: `wmask=0`.
  - `ctrl` stays 0 for 4 cycles, `rout` is unchanged, and `done` pulses.
